// File: rtl/controlador_atendimento_if.sv
// Bundle between the floor-call register bank and the car controller:
// pending-call bits, the bank clear port and the car/door drive outputs.
interface controlador_atendimento_if;
  logic       terreo;
  logic       primeiro_andar;
  logic       segundo_andar;
  logic       terceiro_andar;
  logic [1:0] endereco;
  logic       escrita;
  logic       dado;
  logic [1:0] andar_atual;
  logic       subindo;
  logic       descendo;
  logic       porta_aberta;

  // Controller side: reads calls, drives bank clear port and car outputs
  modport master (
    input  terreo, primeiro_andar, segundo_andar, terceiro_andar,
    output endereco, escrita, dado, andar_atual, subindo, descendo, porta_aberta
  );

  // Bank/car side: presents calls, observes clears and car state
  modport slave (
    output terreo, primeiro_andar, segundo_andar, terceiro_andar,
    input  endereco, escrita, dado, andar_atual, subindo, descendo, porta_aberta
  );
endinterface

// File: rtl/controlador_atendimento.sv
// Four-floor car controller: SCAN service of pending calls, one floor at a
// time, clears each served call in the bank and holds the door open.
module controlador_atendimento #(
  parameter int unsigned TEMPO_ANDAR = 8,
  parameter int unsigned TEMPO_PORTA = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  controlador_atendimento_if.master  bus
);

  localparam int unsigned TEMPO_MAX = (TEMPO_ANDAR > TEMPO_PORTA) ? TEMPO_ANDAR : TEMPO_PORTA;
  localparam int unsigned CW        = (TEMPO_MAX > 1) ? $clog2(TEMPO_MAX) : 1;
  localparam int unsigned NA        = 4;

  typedef enum logic [2:0] {
    PARADO   = 3'd0,
    SUBINDO  = 3'd1,
    DESCENDO = 3'd2,
    LIMPA    = 3'd3,
    PORTA    = 3'd4
  } estado_t;

  estado_t       estado;
  logic [1:0]    andar;
  logic          direcao_sobe;
  logic [CW-1:0] contador;
  logic          flag_subindo;
  logic          flag_descendo;
  logic          flag_escrita;
  logic          flag_porta;

  logic [NA-1:0] req;
  logic [NA-1:0] mask_acima;
  logic [NA-1:0] mask_abaixo;
  logic          acima;
  logic          abaixo;

  // Live call vector and above/below summaries relative to the car
  always_comb begin
    req         = {bus.terceiro_andar, bus.segundo_andar, bus.primeiro_andar, bus.terreo};
    mask_acima  = NA'(4'b1110 << andar);
    mask_abaixo = ~NA'(4'b1111 << andar);
    acima       = |(req & mask_acima);
    abaixo      = |(req & mask_abaixo);
  end

  // Car FSM: decision in PARADO, timed travel and door phases, registered drives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado        <= PARADO;
      andar         <= 2'd0;
      direcao_sobe  <= 1'b1;
      contador      <= '0;
      flag_subindo  <= 1'b0;
      flag_descendo <= 1'b0;
      flag_escrita  <= 1'b0;
      flag_porta    <= 1'b0;
    end else begin
      case (estado)
        PARADO: begin
          if (req[andar]) begin
            estado       <= LIMPA;
            flag_escrita <= 1'b1;
          end else if (direcao_sobe && acima) begin
            estado       <= SUBINDO;
            flag_subindo <= 1'b1;
            contador     <= CW'(TEMPO_ANDAR - 1);
          end else if (!direcao_sobe && abaixo) begin
            estado        <= DESCENDO;
            flag_descendo <= 1'b1;
            contador      <= CW'(TEMPO_ANDAR - 1);
          end else if (acima) begin
            estado       <= SUBINDO;
            flag_subindo <= 1'b1;
            direcao_sobe <= 1'b1;
            contador     <= CW'(TEMPO_ANDAR - 1);
          end else if (abaixo) begin
            estado        <= DESCENDO;
            flag_descendo <= 1'b1;
            direcao_sobe  <= 1'b0;
            contador      <= CW'(TEMPO_ANDAR - 1);
          end
        end

        SUBINDO: begin
          if (contador == '0) begin
            estado       <= PARADO;
            flag_subindo <= 1'b0;
            // acima is never set at the top floor, the guard only keeps andar from wrapping
            if (andar != 2'd3) andar <= andar + 2'd1;
          end else begin
            contador <= contador - CW'(1);
          end
        end

        DESCENDO: begin
          if (contador == '0) begin
            estado        <= PARADO;
            flag_descendo <= 1'b0;
            if (andar != 2'd0) andar <= andar - 2'd1;
          end else begin
            contador <= contador - CW'(1);
          end
        end

        LIMPA: begin
          estado       <= PORTA;
          flag_escrita <= 1'b0;
          flag_porta   <= 1'b1;
          contador     <= CW'(TEMPO_PORTA - 1);
        end

        PORTA: begin
          if (contador == '0) begin
            estado     <= PARADO;
            flag_porta <= 1'b0;
          end else begin
            contador <= contador - CW'(1);
          end
        end

        default: begin
          estado        <= PARADO;
          flag_subindo  <= 1'b0;
          flag_descendo <= 1'b0;
          flag_escrita  <= 1'b0;
          flag_porta    <= 1'b0;
        end
      endcase
    end
  end

  // Drive the bundle; the bank address tracks the current floor and clears always write 0
  assign bus.andar_atual  = andar;
  assign bus.endereco     = andar;
  assign bus.dado         = 1'b0;
  assign bus.escrita      = flag_escrita;
  assign bus.subindo      = flag_subindo;
  assign bus.descendo     = flag_descendo;
  assign bus.porta_aberta = flag_porta;

  // At most one of the car/door/write drives is active at any time
  a_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0({flag_subindo, flag_descendo, flag_escrita, flag_porta}));

  // Drives always agree with the state they belong to
  a_coerente: assert property (@(posedge clk) disable iff (!reset_n)
    (flag_subindo == (estado == SUBINDO)) && (flag_descendo == (estado == DESCENDO)) &&
    (flag_escrita == (estado == LIMPA)) && (flag_porta == (estado == PORTA)));

endmodule
